module_hazard_fwd_ctrl: RTL
===========================

// Module: module_hazard_fwd_ctrl
// PURPOSE
// - Control side of the EX-stage operand-forwarding 3:1 muxes in the 5-stage RV32I pipeline (F/D/E/M/W).
// - Keeps its own shadow pipeline of register IDs and control bits for the instructions in E, M and W.
// - From that state it drives the forward-select codes, load-use and memory-wait stalls, and branch flushes.
// - Holds a saturating counter of stall cycles for performance monitoring.
// PARAMETERS
// - REG_AW  5   register-index width
// - CNT_W   16  stall performance counter width
// PORTS
// - clk_i           in   1       core clock
// - rst_n_i         in   1       async active-low reset
// - rs1_d_i         in   REG_AW  rs1 of the instruction in D
// - rs2_d_i         in   REG_AW  rs2 of the instruction in D
// - rd_d_i          in   REG_AW  rd of the instruction in D
// - reg_write_d_i   in   1       D instruction writes rd
// - result_src_d_i  in   2       D result source; RES_MEM=2'b01 marks a load
// - pc_src_e_i      in   1       branch/jump taken, resolved in E
// - mem_req_m_i     in   1       load/store in M requests data memory
// - mem_ready_i     in   1       data memory completes the M access this cycle
// - fwd_a_e_o       out  2       select for the SrcA forwarding mux
// - fwd_b_e_o       out  2       select for the SrcB forwarding mux
// - stall_f_o       out  1       hold PC
// - stall_d_o       out  1       hold IF/ID
// - stall_e_o       out  1       hold ID/EX
// - stall_m_o       out  1       hold EX/MEM
// - flush_d_o       out  1       clear IF/ID
// - flush_e_o       out  1       clear ID/EX
// - flush_w_o       out  1       clear MEM/WB
// - stall_cnt_o     out  CNT_W   saturating count of stall cycles
// BEHAVIOUR
// - Shadow registers:
//   - E: {rs1, rs2, rd, rw, ld}
//   - M: {rd, rw}
//   - W: {rd, rw}
//   - Each updates on clk_i rising edge and follows the same stall/flush as the datapath register it mirrors.
//   - A flush loads zeros, which makes a bubble.
// - Reset: all shadow state, stall_cnt_o and all outputs are 0 (fwd 2'b00) while rst_n_i=0.
// - Forward-select encoding:
//   - 2'b00 = register-file operand
//   - 2'b01 = W result
//   - 2'b10 = M ALU result
//   - 2'b11 is never driven.
// - fwd_a_e_o (fwd_b_e_o the same with rs2_e):
//   - 2'b10 if rw_m, rd_m!=0 and rd_m==rs1_e.
//   - Else 2'b01 if rw_w, rd_w!=0 and rd_w==rs1_e.
//   - Else 2'b00.
//   - M has priority over W.
// - lwstall: ld_e, rd_e!=0 and (rd_e==rs1_d_i or rd_e==rs2_d_i). Raises stall_f, stall_d and flush_e. One bubble, zero added latency beyond it.
// - memwait: mem_req_m_i and !mem_ready_i.
//   - Raises stall_f/d/e/m and flush_w.
//   - Overrides lwstall and pc_src_e_i: flush_d/flush_e = 0 while waiting.
//   - The branch in E is held and re-asserts pc_src_e_i on the cycle the wait ends.
// - Branch: pc_src_e_i and !memwait raises flush_d and flush_e. lwstall and pc_src_e_i are mutually exclusive (a load is never a branch).
// - Stall/flush outputs are combinational from shadow state and inputs. No registered latency.
// - stall_cnt_o: +1 on each cycle with stall_f_o=1. Saturates at all-ones. Never wraps.
// - Reset mid-operation: async clear of all state. The first cycle after release behaves as an empty pipeline.
// STRUCTURE
// - Shared package pkg_hazard:
//   - typedef enum logic[1:0] fwd_sel_t {FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10}
//   - constants RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10
// - One sub-module module_hazard_shadow_reg #(WIDTH): a register with en (= !stall) and clr (= flush), async reset. Instantiated for the E, M and W shadow stages.
// TESTING
// 1. ALU chain "add x5; sub x6,x5,x1" -> cycle of sub in E: fwd_a_e_o=2'b10. "add x5; nop; or x7,x5,x5" -> fwd_a=fwd_b=2'b01.
// 2. Both M and W write x5, E reads x5 -> 2'b10 (M priority). Any writer with rd=x0 -> 2'b00.
// 3. "lw x5; add x6,x5,x2" -> one cycle stall_f=stall_d=flush_e=1, then fwd_a=2'b01 and no further stall. stall_cnt_o=1.
// 4. mem_req_m_i=1 with mem_ready_i=0 for 3 cycles, plus a taken branch in E -> stall_f/d/e/m=flush_w=1 for 3 cycles, flush_d/e=0. Cycle 4: flush_d=flush_e=1. stall_cnt_o=3.
// 5. Force stall_cnt_o near 2^CNT_W-1 with continuous memwait -> holds at all-ones.
// 6. Assert rst_n_i low mid load-use stall -> all outputs 0 immediately (async). After release, no stall and fwd=2'b00 until new writers are seen.

Source files
------------

// File: rtl/module_hazard_fwd_ctrl_pkg.sv
// module_hazard_fwd_ctrl_pkg: shared forwarding-select and result-source encodings
package pkg_hazard;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_t;
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
endpackage

// File: rtl/module_hazard_fwd_ctrl_if.sv
// module_hazard_fwd_ctrl_if: pipeline <-> hazard unit signal bundle
interface module_hazard_fwd_ctrl_if #(parameter int REG_AW = 5, parameter int CNT_W = 16);
  logic [REG_AW-1:0] rs1_d_i, rs2_d_i, rd_d_i;
  logic              reg_write_d_i;
  logic [1:0]        result_src_d_i;
  logic              pc_src_e_i, mem_req_m_i, mem_ready_i;
  logic [1:0]        fwd_a_e_o, fwd_b_e_o;
  logic              stall_f_o, stall_d_o, stall_e_o, stall_m_o;
  logic              flush_d_o, flush_e_o, flush_w_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  modport master (
    output rs1_d_i, rs2_d_i, rd_d_i, reg_write_d_i, result_src_d_i, pc_src_e_i, mem_req_m_i, mem_ready_i,
    input  fwd_a_e_o, fwd_b_e_o, stall_f_o, stall_d_o, stall_e_o, stall_m_o,
           flush_d_o, flush_e_o, flush_w_o, stall_cnt_o
  );
  modport slave (
    input  rs1_d_i, rs2_d_i, rd_d_i, reg_write_d_i, result_src_d_i, pc_src_e_i, mem_req_m_i, mem_ready_i,
    output fwd_a_e_o, fwd_b_e_o, stall_f_o, stall_d_o, stall_e_o, stall_m_o,
           flush_d_o, flush_e_o, flush_w_o, stall_cnt_o
  );
endinterface

// File: rtl/module_hazard_shadow_reg.sv
// module_hazard_shadow_reg: pipeline shadow register with hold (en=0) and bubble insert (clr)
module module_hazard_shadow_reg #(parameter int WIDTH = 1) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) q <= '0;
    else if (clr) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/module_hazard_fwd_ctrl.sv
// module_hazard_fwd_ctrl: EX forwarding selects, load-use/memory-wait stalls, branch flushes
// and a saturating stall-cycle counter, driven from a shadow pipeline of register IDs.
module module_hazard_fwd_ctrl
  import pkg_hazard::*;
#(parameter int REG_AW = 5, parameter int CNT_W = 16) (
  input logic clk_i,
  input logic rst_n_i,
  module_hazard_fwd_ctrl_if.slave hz
);
  logic [REG_AW-1:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic              rw_e, ld_e, rw_m, rw_w;
  logic              lwstall, memwait, branch;
  logic [CNT_W-1:0]  cnt;
  module_hazard_shadow_reg #(.WIDTH(3*REG_AW+2)) u_e (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en(!memwait), .clr(hz.flush_e_o),
    .d({hz.rs1_d_i, hz.rs2_d_i, hz.rd_d_i, hz.reg_write_d_i, hz.result_src_d_i == RES_MEM}),
    .q({rs1_e, rs2_e, rd_e, rw_e, ld_e})
  );
  module_hazard_shadow_reg #(.WIDTH(REG_AW+1)) u_m (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en(!memwait), .clr(1'b0),
    .d({rd_e, rw_e}), .q({rd_m, rw_m})
  );
  module_hazard_shadow_reg #(.WIDTH(REG_AW+1)) u_w (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en(1'b1), .clr(hz.flush_w_o),
    .d({rd_m, rw_m}), .q({rd_w, rw_w})
  );
  // raw inputs are gated by rst_n_i so every output is quiet while reset is held
  assign memwait = rst_n_i & hz.mem_req_m_i & !hz.mem_ready_i;
  assign lwstall = ld_e & (|rd_e) & ((rd_e == hz.rs1_d_i) | (rd_e == hz.rs2_d_i));
  assign branch  = rst_n_i & hz.pc_src_e_i & !memwait;
  assign hz.fwd_a_e_o = (rw_m && rd_m != '0 && rd_m == rs1_e) ? FWD_MEM :
                        (rw_w && rd_w != '0 && rd_w == rs1_e) ? FWD_WB : FWD_RF;
  assign hz.fwd_b_e_o = (rw_m && rd_m != '0 && rd_m == rs2_e) ? FWD_MEM :
                        (rw_w && rd_w != '0 && rd_w == rs2_e) ? FWD_WB : FWD_RF;
  assign hz.stall_f_o = memwait | lwstall;
  assign hz.stall_d_o = memwait | lwstall;
  assign hz.stall_e_o = memwait;
  assign hz.stall_m_o = memwait;
  assign hz.flush_d_o = branch;
  assign hz.flush_e_o = branch | (lwstall & !memwait);
  assign hz.flush_w_o = memwait;
  assign hz.stall_cnt_o = cnt;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) cnt <= '0;
    else if (hz.stall_f_o && !(&cnt)) cnt <= cnt + 1'b1;
endmodule
